// File: rtl/bcd_subtractor_seq.sv
// Multi-digit packed-BCD subtractor with a borrow chain, one digit per clock, LSD first.
// Latency: start sampled at E0, done pulse and results at E0+DIGITS, back in IDLE at E0+DIGITS+1.
// Backpressure: start is only sampled in IDLE; while busy or done it is ignored, never queued.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start            request, sampled only in IDLE
//   a, b, bin        minuend, subtrahend (packed BCD, digit 0 in [3:0]) and borrow in
//   busy, done       busy while digits are being processed; done is a one-cycle pulse
//   diff, bout       packed-BCD difference (ten's complement when bout=1) and borrow out
//   invalid          an operand digit was >9 in the last operation (diff and bout forced to 0)
module bcd_subtractor_seq #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   input  logic                bin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] diff,
   output logic                bout,
   output logic                invalid
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   // working registers for the operation in flight
   logic [W-1:0]  a_r, b_r, work;
   logic [IW-1:0] idx;
   logic          borrow, err;

   // per-digit combinational datapath
   logic [3:0]    a_dig, b_dig, dig;
   logic [4:0]    t;
   logic          neg, err_nxt, last;
   logic [W-1:0]  work_nxt;

   always_comb begin
      a_dig    = a_r[int'(idx)*4 +: 4];
      b_dig    = b_r[int'(idx)*4 +: 4];
      // 5-bit two's complement: operands are 0..15, so t spans -16..15 and bit 4 is the sign
      t        = {1'b0, a_dig} - {1'b0, b_dig} - {4'd0, borrow};
      neg      = t[4];
      // modulo-16 add of 10 turns -10..-1 into 0..9
      dig      = neg ? (t[3:0] + 4'd10) : t[3:0];
      err_nxt  = err | (a_dig > 4'd9) | (b_dig > 4'd9);
      work_nxt = work;
      work_nxt[int'(idx)*4 +: 4] = dig;
      last     = (idx == LAST_IDX);
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last)  state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         work    <= '0;
         idx     <= '0;
         borrow  <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         bout    <= 1'b0;
         invalid <= 1'b0;
      end else begin
         busy <= (state_nxt == S_RUN);
         done <= (state_nxt == S_DONE);
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_r    <= a;
                  b_r    <= b;
                  borrow <= bin;
                  err    <= 1'b0;
                  idx    <= '0;
                  work   <= '0;
               end
            end
            S_RUN: begin
               borrow <= neg;
               err    <= err_nxt;
               work   <= work_nxt;
               // idx stops at the last digit so it never wraps
               if (!last) idx <= idx + 1'b1;
               if (last) begin
                  // results are committed together on entry to DONE
                  diff    <= err_nxt ? '0 : work_nxt;
                  bout    <= err_nxt ? 1'b0 : neg;
                  invalid <= err_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Self-checking bench for bcd_subtractor_seq: directed cases plus randomized operands
// against a decimal-integer reference model.
// No flow control beyond the start/busy/done handshake.
module tb_bcd_subtractor_seq;

   localparam int D = 4;
   localparam int W = 4 * D;
   localparam int PERIOD = D + 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         bin;
   logic         busy, done, bout, invalid;
   logic [W-1:0] diff;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bcd_subtractor_seq #(.DIGITS(D)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .bin     (bin),
      .busy    (busy),
      .done    (done),
      .diff    (diff),
      .bout    (bout),
      .invalid (invalid)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: interpret operands as decimal integers and subtract with plain arithmetic.
   task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        output logic [W-1:0] d, output logic bo, output logic inv);
      int ai, bi_int, r, modv;
      logic [3:0] na, nb;
      ai = 0; bi_int = 0; modv = 1; inv = 1'b0;
      for (int i = D - 1; i >= 0; i--) begin
         na = av[i*4 +: 4];
         nb = bv[i*4 +: 4];
         if (na > 9 || nb > 9) inv = 1'b1;
         ai     = ai * 10 + int'(na);
         bi_int = bi_int * 10 + int'(nb);
         modv   = modv * 10;
      end
      r  = ai - bi_int - (bi ? 1 : 0);
      bo = (r < 0);
      if (r < 0) r = r + modv;
      d = '0;
      for (int i = 0; i < D; i++) begin
         d[i*4 +: 4] = 4'(r % 10);
         r = r / 10;
      end
      if (inv) begin
         d  = '0;
         bo = 1'b0;
      end
   endtask

   function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
      logic [W-1:0] v;
      for (int i = 0; i < D; i++) begin
         if (allow_bad && ($urandom_range(0, 5) == 0)) v[i*4 +: 4] = 4'($urandom_range(10, 15));
         else                                           v[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      return v;
   endfunction

   // One operation from IDLE: pulse start, scramble operands after acceptance,
   // check latency, output stability during RUN, results, and the one-cycle done.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                         input logic [W-1:0] ed, input logic eb, input logic ei);
      logic [W-1:0] prev_diff;
      int cnt;
      @(negedge clk);
      a = av; b = bv; bin = bi; start = 1'b1;
      prev_diff = diff;
      @(negedge clk);                       // E0 has passed
      start = 1'b0;
      a = rand_bcd(1'b1); b = rand_bcd(1'b1); bin = 1'($urandom_range(0, 1));
      check("busy_after_e0", busy, 1'b1);
      cnt = 0;
      while (!done && cnt < 3 * D) begin
         check("diff_hold_run", diff, prev_diff);
         @(negedge clk);
         cnt++;
      end
      check("done_latency", cnt, D);
      check("diff", diff, ed);
      check("bout", bout, eb);
      check("invalid", invalid, ei);
      check("busy_at_done", busy, 1'b0);
      @(negedge clk);
      check("done_pulse_width", done, 1'b0);
      check("busy_after_done", busy, 1'b0);
      check("diff_hold_idle", diff, ed);
   endtask

   task automatic run_rand(input bit allow_bad);
      logic [W-1:0] av, bv, ed;
      logic bi, eb, ei;
      av = rand_bcd(allow_bad);
      bv = rand_bcd(allow_bad);
      bi = 1'($urandom_range(0, 1));
      model(av, bv, bi, ed, eb, ei);
      run_op(av, bv, bi, ed, eb, ei);
   endtask

   logic [W-1:0] ops_a [0:4*PERIOD+1];
   logic [W-1:0] ops_b [0:4*PERIOD+1];
   logic         ops_c [0:4*PERIOD+1];

   initial begin
      logic [W-1:0] ed, held_diff;
      logic eb, ei;
      int k;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      #3;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_diff", diff, '0);
      check("rst_bout", bout, 1'b0);
      check("rst_invalid", invalid, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // directed cases with hand-derived results
      run_op(16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0);
      run_op(16'h0017, 16'h0042, 1'b0, 16'h9975, 1'b1, 1'b0);
      run_op(16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0);
      run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
      run_op(16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0);
      run_op(16'h00A1, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
      run_op(16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0);
      run_op(16'h0005, 16'hF000, 1'b0, 16'h0000, 1'b0, 1'b1);
      run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

      // randomized
      for (int i = 0; i < 20; i++) run_rand(1'b0);
      for (int i = 0; i < 10; i++) run_rand(1'b1);

      // start held high, operands changing every cycle
      @(negedge clk);
      for (int m = 0; m <= 4 * PERIOD + 1; m++) begin
         if (m > 0) begin
            check("hold_done_timing", done, ((m - 1) % PERIOD) == D);
            if (((m - 1) % PERIOD) == D) begin
               k = ((m - 1) / PERIOD) * PERIOD;
               model(ops_a[k], ops_b[k], ops_c[k], ed, eb, ei);
               check("hold_diff", diff, ed);
               check("hold_bout", bout, eb);
               check("hold_invalid", invalid, ei);
               held_diff = diff;
            end else if (m > D + 1) begin
               check("hold_stable", diff, held_diff);
            end
         end
         ops_a[m] = rand_bcd(1'b0);
         ops_b[m] = rand_bcd(1'b0);
         ops_c[m] = 1'($urandom_range(0, 1));
         a = ops_a[m]; b = ops_b[m]; bin = ops_c[m]; start = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      repeat (PERIOD) @(negedge clk);

      // make sure the outputs are nonzero before the mid-operation reset
      run_op(16'h0017, 16'h0042, 1'b0, 16'h9975, 1'b1, 1'b0);
      @(negedge clk);
      a = 16'h0042; b = 16'h0017; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);                       // E1
      @(posedge clk);                       // E2
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_diff", diff, '0);
      check("arst_bout", bout, 1'b0);
      check("arst_invalid", invalid, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < PERIOD + 2; i++) begin
         @(negedge clk);
         check("no_done_after_arst", done, 1'b0);
         check("idle_after_arst", busy, 1'b0);
      end
      run_op(16'h5000, 16'h0001, 1'b1, 16'h4998, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // hard stop in case anything above stalls
   initial begin
      #200000;
      $display("FAIL timeout: got stalled expected finish");
      $fatal(1, "timeout");
   end

endmodule
